// File: rtl/udp_pkt_pkg.sv
// Constants shared by the UDP depacketizer and the transmit packetizer:
// header field values, header word indices, the parser state type and small helpers.
package udp_pkt_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [15:0] IP_TOTAL_LEN   = 16'h05dc;
  localparam logic [15:0] UDP_TOTAL_LEN  = 16'h05c8;

  localparam int unsigned WIDX_W = 4;
  typedef logic [WIDX_W-1:0] widx_t;

  // Word indices of a shift-16 frame (2 pad bytes ahead of the destination MAC)
  localparam widx_t W_MAC_HI   = 4'd0;
  localparam widx_t W_MAC_LO   = 4'd1;
  localparam widx_t W_ETYPE    = 4'd3;
  localparam widx_t W_IP_VER   = 4'd4;
  localparam widx_t W_IP_PROTO = 4'd6;
  localparam widx_t W_IP_DST   = 4'd8;
  localparam widx_t W_UDP_PORT = 4'd9;
  localparam widx_t W_UDP_LEN  = 4'd10;
  localparam widx_t W_SEQ_LO   = 4'd11;
  localparam widx_t W_SEQ_HI   = 4'd12;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    COUNTER,
    PAYLOAD,
    DROP
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, v} + {15'd0, n};
    return s[16] ? '1 : s[15:0];
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/udp_hdr_check.sv
// Combinational header word check: given the word index within the frame and the
// beat contents, reports whether that word matches the accepted header.
module udp_hdr_check
  import udp_pkt_pkg::*;
#(
  parameter logic [47:0] local_mac  = 48'h021234566790,
  parameter logic [31:0] local_ip   = {8'd192, 8'd168, 8'd50, 8'd50},
  parameter logic [15:0] local_port = 16'd32179
) (
  input  widx_t       idx,
  input  logic [31:0] data,
  output logic        ok
);

  always_comb begin
    ok = 1'b1;
    case (idx)
      W_MAC_HI:   ok = (data[15:0] == local_mac[47:32]);
      W_MAC_LO:   ok = (data == local_mac[31:0]);
      W_ETYPE:    ok = (data[15:0] == ETHERTYPE_IPV4);
      W_IP_VER:   ok = (data[31:24] == IP_VER_IHL) && (data[15:0] == IP_TOTAL_LEN);
      W_IP_PROTO: ok = (data[23:16] == IP_PROTO_UDP);
      W_IP_DST:   ok = (data == local_ip);
      W_UDP_PORT: ok = (data[15:0] == local_port);
      W_UDP_LEN:  ok = (data[31:16] == UDP_TOTAL_LEN);
      default:    ok = 1'b1;
    endcase
  end

endmodule

// File: rtl/udp_depacketizer.sv
// UDP IQ-stream receiver: filters MAC RX frames on MAC/IP/port, tracks a 64-bit
// sequence number and writes byte-swapped IQ samples into the serializer FIFO.
module udp_depacketizer
  import udp_pkt_pkg::*;
#(
  parameter logic [47:0] local_mac  = 48'h021234566790,
  parameter logic [31:0] local_ip   = {8'd192, 8'd168, 8'd50, 8'd50},
  parameter logic [15:0] local_port = 16'd32179,
  parameter int unsigned iq_words   = 366
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] rx_data,
  input  logic        rx_sop,
  input  logic        rx_eop,
  input  logic        rx_err,
  input  logic [1:0]  rx_mod,
  input  logic        rx_dval,
  output logic        rx_rdy,
  output logic        wr_en,
  output logic [31:0] wr_data,
  input  logic        wr_full,
  output logic [31:0] pkt_count,
  output logic [15:0] drop_count,
  output logic [15:0] err_count,
  output logic [15:0] gap_count,
  output logic        seq_gap
);

  localparam logic [15:0] IQ_MAX = 16'(iq_words);

  state_t      state;
  state_t      eff_state;
  widx_t       idx;
  widx_t       cur_idx;
  logic [15:0] wcnt;
  logic [31:0] seq_lo;
  logic [63:0] last_seq;
  logic        last_vld;
  logic [63:0] seq;
  logic        acc;
  logic        hdr_ok;
  logic        abort;
  logic        hdr_end;
  logic        wr_ok;
  logic        short_pkt;
  logic        unused_mod;

  assign unused_mod = ^rx_mod;

  assign rx_rdy  = !reset_n || (state != PAYLOAD) || !wr_full;
  assign acc     = rx_dval && rx_rdy;
  assign cur_idx = rx_sop ? '0 : idx;
  assign seq     = {bswap32(rx_data), seq_lo};

  udp_hdr_check #(
    .local_mac (local_mac),
    .local_ip  (local_ip),
    .local_port(local_port)
  ) u_hdr_check (
    .idx (cur_idx),
    .data(rx_data),
    .ok  (hdr_ok)
  );

  // An sop beat restarts parsing from whatever state we were in, so the beat is
  // handled as a HEADER word while the interrupted frame is counted as a drop.
  always_comb begin
    eff_state = rx_sop ? HEADER : state;
    abort     = acc && rx_sop && (state != IDLE);
    hdr_end   = acc && rx_eop &&
                (eff_state == HEADER || eff_state == COUNTER || eff_state == DROP);
    wr_ok     = (wcnt < IQ_MAX);
    short_pkt = wr_ok && ((wcnt + 16'd1) < IQ_MAX);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      wcnt       <= '0;
      seq_lo     <= '0;
      last_seq   <= '0;
      last_vld   <= 1'b0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      seq_gap    <= 1'b0;
      pkt_count  <= '0;
      drop_count <= '0;
      err_count  <= '0;
      gap_count  <= '0;
    end else begin
      wr_en   <= 1'b0;
      seq_gap <= 1'b0;
      if (acc) begin
        case (eff_state)
          HEADER: begin
            idx <= cur_idx + widx_t'(1);
            if (rx_eop)                    state <= IDLE;
            else if (!hdr_ok)              state <= DROP;
            else if (cur_idx == W_UDP_LEN) state <= COUNTER;
            else                           state <= HEADER;
          end
          COUNTER: begin
            idx  <= idx + widx_t'(1);
            wcnt <= '0;
            if (idx == W_SEQ_LO) begin
              seq_lo <= bswap32(rx_data);
            end else begin
              if (last_vld && (seq != last_seq + 64'd1)) begin
                seq_gap   <= 1'b1;
                gap_count <= sat_inc16(gap_count);
              end
              last_seq <= seq;
              last_vld <= 1'b1;
            end
            if (rx_eop)               state <= IDLE;
            else if (idx == W_SEQ_HI) state <= PAYLOAD;
            else                      state <= COUNTER;
          end
          PAYLOAD: begin
            if (wr_ok) begin
              wr_en   <= 1'b1;
              wr_data <= {rx_data[23:16], rx_data[31:24], rx_data[7:0], rx_data[15:8]};
              wcnt    <= wcnt + 16'd1;
            end
            if (rx_eop) begin
              state     <= IDLE;
              pkt_count <= pkt_count + 32'd1;
              if (rx_err || short_pkt) err_count <= sat_inc16(err_count);
            end
          end
          DROP: begin
            if (rx_eop) state <= IDLE;
          end
          default: ;
        endcase
      end
      drop_count <= sat_add16(drop_count, {1'b0, abort} + {1'b0, hdr_end});
    end
  end

endmodule

// File: tb/tb_udp_depacketizer.sv
// Bench for udp_depacketizer: table of frame vectors, hand-built abort/reset/backpressure
// sequences, and randomized frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_udp_depacketizer;

  localparam logic [47:0] MAC  = 48'h021234566790;
  localparam logic [31:0] IP   = {8'd192, 8'd168, 8'd50, 8'd50};
  localparam logic [15:0] PORT = 16'd32179;
  localparam int          IQ   = 366;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_sop = 1'b0, rx_eop = 1'b0, rx_err = 1'b0, rx_dval = 1'b0;
  logic [1:0]  rx_mod = '0;
  logic        rx_rdy;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_full = 1'b0;
  logic [31:0] pkt_count;
  logic [15:0] drop_count, err_count, gap_count;
  logic        seq_gap;

  udp_depacketizer #(
    .local_mac (MAC),
    .local_ip  (IP),
    .local_port(PORT),
    .iq_words  (IQ)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .rx_err(rx_err), .rx_mod(rx_mod), .rx_dval(rx_dval), .rx_rdy(rx_rdy),
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .pkt_count(pkt_count),
    .drop_count(drop_count), .err_count(err_count), .gap_count(gap_count), .seq_gap(seq_gap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          bad;     // 0 = clean header, else index of corrupted field
    logic [63:0] seq;
    int          nsamp;
    int          len;     // 0 = whole frame, else truncate to this many beats
    bit          err;
    int          exp_wr;  // writes expected from this frame
    int          exp_pkt, exp_drop, exp_err, exp_gap;  // cumulative
  } vec_t;

  int          n_chk = 0, n_fail = 0;
  logic [31:0] frm[$];
  logic [31:0] smp[$];
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int          wr_seen = 0, gap_seen = 0;
  int          m_pkt = 0, m_drop = 0, m_err = 0, m_gap = 0;
  logic [63:0] m_last = '0;
  bit          m_have = 0;
  bit          rdy_must = 0;
  vec_t        tbl[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      wr_seen++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_data: unexpected write %h", wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (wr_data !== mon_exp) begin
          n_fail++;
          $display("FAIL wr_data: got %h expected %h", wr_data, mon_exp);
        end
      end
    end
    if (seq_gap) gap_seen++;
  end

  function automatic logic [31:0] le32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic vec_t mk(input int bad, input logic [63:0] seq, input int ns, input int len,
                              input bit err, input int wr, input int p, input int d,
                              input int e, input int g);
    vec_t v;
    v.bad = bad; v.seq = seq; v.nsamp = ns; v.len = len; v.err = err;
    v.exp_wr = wr; v.exp_pkt = p; v.exp_drop = d; v.exp_err = e; v.exp_gap = g;
    return v;
  endfunction

  // Frame image on the wire; smp holds each sample as {I,Q}
  task automatic build(input int bad, input logic [63:0] seq, input int nsamp, input int len,
                       input logic [31:0] fixed);
    logic [47:0] mac;
    logic [31:0] ip, iq;
    logic [15:0] port, et, iplen, ulen;
    logic [7:0]  ver, proto;
    mac = MAC; ip = IP; port = PORT; et = 16'h0800; ver = 8'h45;
    iplen = 16'h05dc; proto = 8'h11; ulen = 16'h05c8;
    case (bad)
      1: mac[40] = ~mac[40];
      2: mac[0] = ~mac[0];
      3: et = 16'h86dd;
      4: ver = 8'h46;
      5: iplen = 16'h05dd;
      6: proto = 8'h06;
      7: ip[0] = ~ip[0];
      8: port = 16'd1234;
      9: ulen = 16'h05c9;
      default: ;
    endcase
    frm.delete(); smp.delete();
    frm.push_back({16'($urandom()), mac[47:32]});
    frm.push_back(mac[31:0]);
    frm.push_back($urandom());
    frm.push_back({16'($urandom()), et});
    frm.push_back({ver, 8'($urandom()), iplen});
    frm.push_back($urandom());
    frm.push_back({8'($urandom()), proto, 16'($urandom())});
    frm.push_back($urandom());
    frm.push_back(ip);
    frm.push_back({16'($urandom()), port});
    frm.push_back({ulen, 16'($urandom())});
    frm.push_back(le32(seq[31:0]));
    frm.push_back(le32(seq[63:32]));
    for (int k = 0; k < nsamp; k++) begin
      iq = (fixed != 0) ? fixed : $urandom();
      smp.push_back(iq);
      frm.push_back({iq[23:16], iq[31:24], iq[7:0], iq[15:8]});
    end
    if (len > 0) while (frm.size() > len) void'(frm.pop_back());
  endtask

  task automatic drive(input int i, input bit dv, input bit last, input bit err);
    rx_dval = dv;
    rx_mod  = 2'($urandom());
    if (dv) begin
      rx_data = frm[i];
      rx_sop  = (i == 0);
      rx_eop  = last;
      rx_err  = last ? err : 1'($urandom());
    end else begin
      rx_data = $urandom();
      rx_sop  = 1'($urandom());
      rx_eop  = 1'($urandom());
      rx_err  = 1'($urandom());
    end
  endtask

  // Presents beats first..stop-1; hold_at forces wr_full for 10 cycles at that beat
  task automatic send(input bit err, input int first, input int stop, input int hold_at);
    int i, guard;
    bit acc, dv, held, last;
    i = first; guard = 0; held = 0;
    while (i < stop) begin
      @(negedge clk);
      last = (i == frm.size() - 1) && (stop == frm.size());
      if (i == hold_at && !held) begin
        held = 1;
        wr_full = 1'b1;
        drive(i, 1'b1, last, err);
        repeat (10) begin
          #1;
          chk("rx_rdy_while_full", rx_rdy, 1'b0);
          @(negedge clk);
        end
      end
      wr_full = ($urandom_range(0, 9) == 0);
      dv = ($urandom_range(0, 4) != 0);
      drive(i, dv, last, err);
      #1;
      if (rdy_must) chk("rx_rdy_high", rx_rdy, 1'b1);
      acc = rx_dval && rx_rdy;
      @(posedge clk);
      if (acc) begin
        i++;
        guard = 0;
      end else if (++guard > 200) begin
        n_chk++; n_fail++;
        $display("FAIL beat_timeout: beat %0d not accepted within 200 cycles", i);
        break;
      end
    end
    @(negedge clk);
    rx_dval = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; wr_full = 1'b0;
  endtask

  // Frame-level reference: what a complete frame contributes to FIFO and counters
  task automatic model_frame(input int bad, input int len, input int nsamp,
                             input logic [63:0] seq, input bit err);
    if (bad == 0 && len == 0) begin
      for (int k = 0; k < nsamp && k < IQ; k++) exp_q.push_back(smp[k]);
      m_pkt++;
      if (err || nsamp < IQ) m_err++;
      if (m_have && seq != m_last + 64'd1) m_gap++;
      m_last = seq;
      m_have = 1;
    end else begin
      m_drop++;
    end
  endtask

  task automatic check_counts();
    repeat (3) @(negedge clk);
    chk("pkt_count", pkt_count, 64'(m_pkt));
    chk("drop_count", drop_count, 64'(m_drop));
    chk("err_count", err_count, 64'(m_err));
    chk("gap_count", gap_count, 64'(m_gap));
    chk("seq_gap_pulses", 64'(gap_seen), 64'(m_gap));
    chk("writes_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_frame(input int bad, input int len, input int nsamp,
                           input logic [63:0] seq, input bit err);
    build(bad, seq, nsamp, len, 32'h0);
    model_frame(bad, len, nsamp, seq, err);
    send(err, 0, frm.size(), -1);
    check_counts();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    int          w0, bad, len, ns;
    logic [63:0] sq;
    bit          er;

    tbl[0]  = mk(0, 64'd5,   366, 0,  0, 366, 1, 0, 0, 0);
    tbl[1]  = mk(8, 64'd6,   366, 0,  0, 0,   1, 1, 0, 0);
    tbl[2]  = mk(0, 64'd7,   366, 0,  0, 366, 2, 1, 0, 1);
    tbl[3]  = mk(0, '1,      366, 0,  0, 366, 3, 1, 0, 2);
    tbl[4]  = mk(0, 64'd0,   366, 0,  0, 366, 4, 1, 0, 2);
    tbl[5]  = mk(0, 64'd1,   100, 0,  1, 100, 5, 1, 1, 2);
    tbl[6]  = mk(1, 64'd2,   366, 0,  0, 0,   5, 2, 1, 2);
    tbl[7]  = mk(0, 64'd2,   400, 0,  0, 366, 6, 2, 1, 2);
    tbl[8]  = mk(0, 64'd3,   365, 0,  0, 365, 7, 2, 2, 2);
    tbl[9]  = mk(3, 64'd4,   366, 0,  0, 0,   7, 3, 2, 2);
    tbl[10] = mk(0, 64'd4,   366, 11, 0, 0,   7, 4, 2, 2);
    tbl[11] = mk(6, 64'd4,   366, 0,  0, 0,   7, 5, 2, 2);
    tbl[12] = mk(9, 64'd4,   366, 0,  0, 0,   7, 6, 2, 2);
    tbl[13] = mk(4, 64'd4,   366, 0,  0, 0,   7, 7, 2, 2);
    tbl[14] = mk(0, 64'd4,   366, 0,  1, 366, 8, 7, 3, 2);
    tbl[15] = mk(7, 64'd5,   366, 0,  0, 0,   8, 8, 3, 2);
    tbl[16] = mk(0, 64'd5,   1,   0,  0, 1,   9, 8, 4, 2);

    reset_n = 1'b0;
    wr_full = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rx_rdy", rx_rdy, 1'b1);
    chk("reset_wr_en", wr_en, 1'b0);
    chk("reset_wr_data", wr_data, 32'h0);
    chk("reset_seq_gap", seq_gap, 1'b0);
    chk("reset_pkt_count", pkt_count, 32'h0);
    chk("reset_drop_count", drop_count, 16'h0);
    wr_full = 1'b0;
    reset_n = 1'b1;

    for (int t = 0; t < 17; t++) begin
      v = tbl[t];
      build(v.bad, v.seq, v.nsamp, v.len, (t == 0) ? 32'h22114433 : 32'h0);
      for (int k = 0; k < v.exp_wr; k++) exp_q.push_back(smp[k]);
      rdy_must = (v.bad != 0);
      w0 = wr_seen;
      send(v.err, 0, frm.size(), -1);
      rdy_must = 0;
      repeat (3) @(negedge clk);
      chk("vec_writes", 64'(wr_seen - w0), 64'(v.exp_wr));
      chk("vec_pkt_count", pkt_count, 64'(v.exp_pkt));
      chk("vec_drop_count", drop_count, 64'(v.exp_drop));
      chk("vec_err_count", err_count, 64'(v.exp_err));
      chk("vec_gap_count", gap_count, 64'(v.exp_gap));
      chk("vec_gap_pulses", 64'(gap_seen), 64'(v.exp_gap));
      chk("vec_pending", 64'(exp_q.size()), 64'd0);
    end
    m_pkt = 9; m_drop = 8; m_err = 4; m_gap = 2; m_last = 64'd5; m_have = 1;

    // FIFO backpressure held for 10 cycles in the middle of the payload
    build(0, 64'd6, 366, 0, 32'h0);
    model_frame(0, 0, 366, 64'd6, 0);
    send(0, 0, frm.size(), 113);
    check_counts();

    // sop during HEADER, then sop during PAYLOAD after 10 samples
    build(0, 64'd7, 366, 0, 32'h0);
    send(0, 0, 6, -1);
    m_drop++;
    run_frame(0, 0, 366, 64'd7, 0);
    build(0, 64'd8, 366, 0, 32'h0);
    for (int k = 0; k < 10; k++) exp_q.push_back(smp[k]);
    m_last = 64'd8;
    send(0, 0, 23, -1);
    m_drop++;
    run_frame(0, 0, 200, 64'd9, 0);

    // Reset while w20 is presented; the tail without sop must be ignored
    build(0, 64'd10, 366, 0, 32'h0);
    for (int k = 0; k < 7; k++) exp_q.push_back(smp[k]);
    send(0, 0, 20, -1);
    wr_full = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("rx_rdy_in_reset", rx_rdy, 1'b1);
    @(negedge clk);
    chk("mid_reset_wr_en", wr_en, 1'b0);
    chk("mid_reset_pkt_count", pkt_count, 32'h0);
    chk("mid_reset_drop_count", drop_count, 16'h0);
    chk("mid_reset_err_count", err_count, 16'h0);
    chk("mid_reset_gap_count", gap_count, 16'h0);
    reset_n = 1'b1;
    wr_full = 1'b0;
    m_pkt = 0; m_drop = 0; m_err = 0; m_gap = 0; m_have = 0; gap_seen = 0;
    w0 = wr_seen;
    send(0, 20, 41, -1);
    check_counts();
    chk("tail_writes", 64'(wr_seen - w0), 64'd0);
    w0 = wr_seen;
    run_frame(0, 0, 366, 64'd1000, 0);
    chk("post_reset_writes", 64'(wr_seen - w0), 64'd366);

    // Randomized frames against the frame-level model
    for (int r = 0; r < 25; r++) begin
      bad = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 9));
      len = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 12)) : 0;
      ns  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(360, 420)) : int'($urandom_range(1, 120));
      sq  = ($urandom_range(0, 9) < 7) ? m_last + 64'd1 : {32'($urandom()), 32'($urandom())};
      er  = ($urandom_range(0, 3) == 0);
      run_frame(bad, len, ns, sq, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
